// File: rtl/cpu_noc_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_noc_tx_arbiter_pkg
// Description : Shared types and constants for the CPU-to-NoC TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_noc_tx_arbiter_pkg;

  localparam int c_node_id_w = 8;
  localparam int c_max_beats = 16;

  // Node id type shared with cpu_to_noc_flitizer.
  typedef logic [c_node_id_w-1:0] node_id_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_DRAIN  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_noc_tx_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker: first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int c_iw = $clog2(N);

  logic [c_iw:0] w_sum;

  // Scan offsets from the far end so the smallest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (c_iw + 1)'(k);
      if (w_sum >= (c_iw + 1)'(N)) begin
        w_sum = w_sum - (c_iw + 1)'(N);
      end
      if (req[w_sum[c_iw-1:0]]) begin
        found = 1'b1;
        idx   = w_sum[c_iw-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_noc_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_noc_tx_arbiter
// Description : Round-robin, packet-locked arbiter feeding one flitizer,
//               with max-length truncation and drain of overlong packets.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_noc_tx_arbiter
  import cpu_noc_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int NODE_ID_WIDTH = c_node_id_w,
  parameter int MAX_BEATS     = c_max_beats
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*NODE_ID_WIDTH-1:0] req_dst,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic                             fl_valid,
  input  logic                             fl_ready,
  output logic [DATA_WIDTH-1:0]            fl_data,
  output logic [NODE_ID_WIDTH-1:0]         fl_dst,
  output logic                             fl_last,
  output logic [$clog2(NUM_REQ)-1:0]       fl_src,
  output logic                             busy,
  output logic                             overrun_err
);

  localparam int c_sw = $clog2(NUM_REQ);
  localparam int c_cw = $clog2(MAX_BEATS) + 1;

  arb_state_e               r_state;
  arb_state_e               w_state_nxt;
  logic [c_sw-1:0]          r_grant;
  logic [c_sw-1:0]          r_rr_ptr;
  logic [c_sw-1:0]          w_pick;
  logic [c_sw-1:0]          w_grant_inc;
  logic [c_cw-1:0]          r_beat_cnt;
  logic [NODE_ID_WIDTH-1:0] r_dst;
  logic                     r_overrun;
  logic                     w_found;
  logic                     w_cur_valid;
  logic                     w_cur_last;
  logic                     w_cnt_max;
  logic                     w_start;
  logic                     w_xfer;
  logic                     w_trunc;
  logic                     w_done;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_cur_valid = req_valid[r_grant];
  assign w_cur_last  = req_last[r_grant];
  assign w_cnt_max   = (r_beat_cnt == c_cw'(MAX_BEATS - 1));
  assign w_grant_inc = (r_grant == c_sw'(NUM_REQ - 1)) ? '0 : r_grant + c_sw'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    fl_valid    = 1'b0;
    fl_data     = '0;
    fl_last     = 1'b0;
    w_start     = 1'b0;
    w_xfer      = 1'b0;
    w_trunc     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        // Straight pass-through of the granted requester; no buffering.
        fl_valid           = w_cur_valid;
        fl_data            = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
        fl_last            = w_cur_last | w_cnt_max;
        req_ready[r_grant] = fl_ready;
        w_xfer             = w_cur_valid & fl_ready;
        if (w_xfer) begin
          if (w_cur_last) begin
            w_done      = 1'b1;
            w_state_nxt = ARB_IDLE;
          end else if (w_cnt_max) begin
            w_trunc     = 1'b1;
            w_state_nxt = ARB_DRAIN;
          end
        end
      end
      ARB_DRAIN: begin
        // Swallow the tail of a truncated packet until its real last beat.
        req_ready[r_grant] = 1'b1;
        if (w_cur_valid && w_cur_last) begin
          w_done      = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_dst      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_trunc;
      if (w_start) begin
        r_grant    <= w_pick;
        r_dst      <= req_dst[w_pick*NODE_ID_WIDTH +: NODE_ID_WIDTH];
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + c_cw'(1);
      end
      // The requester just served drops to lowest priority.
      if (w_done) begin
        r_rr_ptr <= w_grant_inc;
      end
    end
  end

  assign fl_dst      = r_dst;
  assign fl_src      = r_grant;
  assign busy        = (r_state != ARB_IDLE);
  assign overrun_err = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cpu_noc_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_noc_tx_arbiter
// Description : Directed, self-checking bench for cpu_noc_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_noc_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int NW = 8;
  localparam int MB = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NW-1:0] dst;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_data;
  logic [NR*NW-1:0] req_dst;
  logic [NR-1:0]  req_last;
  logic           fl_valid;
  logic           fl_ready;
  logic [DW-1:0]  fl_data;
  logic [NW-1:0]  fl_dst;
  logic           fl_last;
  logic [1:0]     fl_src;
  logic           busy;
  logic           overrun_err;

  cpu_noc_tx_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .NODE_ID_WIDTH (NW),
    .MAX_BEATS     (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_dst     (req_dst),
    .req_last    (req_last),
    .fl_valid    (fl_valid),
    .fl_ready    (fl_ready),
    .fl_data     (fl_data),
    .fl_dst      (fl_dst),
    .fl_last     (fl_last),
    .fl_src      (fl_src),
    .busy        (busy),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester sources and captured output beats.
  beat_t         q[NR][$];
  logic [NR-1:0] fired = '0;
  bit            tog = 1'b0;
  int            cyc = 0;
  int            ovr_cnt = 0;
  logic [DW-1:0] out_d[$];
  int            out_src[$];
  bit            out_last[$];
  logic [NW-1:0] out_dst[$];
  int            out_cyc[$];

  // Reference model state (packet level).
  int            m_owner = -1;
  int            m_sent = 0;
  int            m_ptr = 0;
  int            m_src = 0;
  bit            m_drain = 1'b0;
  bit            m_pulse = 1'b0;
  logic [NW-1:0] m_dst = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() > 0) begin
        b = q[i][0];
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = b.d;
        req_dst[i*NW +: NW]     = b.dst;
        req_last[i]             = b.last;
      end else begin
        req_valid[i]            = 1'b0;
        req_data[i*DW +: DW]    = '0;
        req_dst[i*NW +: NW]     = '0;
        req_last[i]             = 1'b0;
      end
    end
  endtask

  // Beats after the first carry a different dst, which must be ignored.
  task automatic push_pkt(input int r, input int n, input logic [DW-1:0] base,
                          input logic [NW-1:0] dst);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d    = base + DW'(k);
      b.dst  = (k == 0) ? dst : ~dst;
      b.last = (k == n - 1);
      q[r].push_back(b);
    end
    drive();
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2;
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
          q[3].size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_idle_reached"}, ok, 1'b1);
  endtask

  task automatic chk_out(input string nm, input int idx, input logic [DW-1:0] d,
                         input int src, input logic [NW-1:0] dst, input bit last);
    chk({nm, "_present"}, idx < out_d.size(), 1'b1);
    if (idx < out_d.size()) begin
      chk({nm, "_data"}, out_d[idx], d);
      chk({nm, "_src"}, out_src[idx], src);
      chk({nm, "_dst"}, out_dst[idx], dst);
      chk({nm, "_last"}, out_last[idx], last);
    end
  endtask

  // Source BFM: retire accepted beats, present the next ones.
  always @(posedge clk) begin : src_drv
    beat_t b;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fired[i] && q[i].size() > 0) begin
        b = q[i].pop_front();
      end
    end
    drive();
    if (tog) fl_ready = ~fl_ready;
  end

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin : cmp
    logic [NR-1:0] e_rdy;
    bit            got;
    int            i;
    cyc++;
    if (rst) begin
      chk("rst_outputs", {busy, fl_valid, req_ready, fl_data, fl_dst, fl_last, fl_src,
                          overrun_err}, '0);
      m_owner = -1; m_sent = 0; m_ptr = 0; m_src = 0;
      m_drain = 1'b0; m_pulse = 1'b0; m_dst = '0;
      fired = '0;
    end else begin
      e_rdy = '0;
      if (m_owner >= 0) begin
        if (m_drain) begin
          e_rdy[m_owner] = 1'b1;
        end else begin
          e_rdy[m_owner] = fl_ready;
          chk("fl_data", fl_data, req_data[m_owner*DW +: DW]);
          chk("fl_last", fl_last, req_last[m_owner] || (m_sent == MB - 1));
        end
      end
      chk("busy", busy, m_owner >= 0);
      chk("fl_valid", fl_valid, (m_owner >= 0) && !m_drain && req_valid[m_owner]);
      chk("req_ready", req_ready, e_rdy);
      chk("fl_dst", fl_dst, m_dst);
      chk("fl_src", fl_src, m_src);
      chk("overrun_err", overrun_err, m_pulse);
      if (overrun_err) ovr_cnt++;

      if (fl_valid && fl_ready) begin
        out_d.push_back(fl_data);
        out_src.push_back(int'(fl_src));
        out_dst.push_back(fl_dst);
        out_last.push_back(fl_last);
        out_cyc.push_back(cyc);
      end
      fired = req_valid & req_ready;

      m_pulse = 1'b0;
      if (m_owner < 0) begin
        got = 1'b0;
        for (int k = 0; k < NR; k++) begin
          i = (m_ptr + k) % NR;
          if (!got && req_valid[i]) begin
            got = 1'b1;
            m_owner = i; m_src = i; m_sent = 0; m_drain = 1'b0;
            m_dst = req_dst[i*NW +: NW];
          end
        end
      end else if (!m_drain) begin
        if (req_valid[m_owner] && fl_ready) begin
          m_sent++;
          if (req_last[m_owner]) begin
            m_ptr = (m_owner + 1) % NR;
            m_owner = -1;
          end else if (m_sent == MB) begin
            m_drain = 1'b1;
            m_pulse = 1'b1;
          end
        end
      end else if (req_valid[m_owner] && req_last[m_owner]) begin
        m_ptr = (m_owner + 1) % NR;
        m_owner = -1;
        m_drain = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] t1_d [8];
    int            t1_s [8];
    int            s;
    int            rel;
    bit            got;

    t1_d = '{32'h1000_0000, 32'h1000_0010, 32'h1000_0020, 32'h1000_0030,
             32'h1000_0001, 32'h1000_0011, 32'h1000_0021, 32'h1000_0031};
    t1_s = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1'b1;
    fl_ready = 1'b0;
    drive();

    // Reset with every requester valid; then 1-beat packets rotate 0,1,2,3,0,..
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NR; r++)
        push_pkt(r, 1, 32'h1000_0000 | DW'(r * 16 + p), NW'(8'h40 + r));
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("t1_rst_fl_valid", fl_valid, 1'b0);
    chk("t1_rst_req_ready", req_ready, '0);
    chk("t1_rst_busy", busy, 1'b0);
    fl_ready = 1'b1;
    rst = 1'b0;
    rel = cyc;
    wait_idle("t1");
    chk("t1_count", out_d.size(), 8);
    for (int k = 0; k < 8; k++)
      chk_out("t1", k, t1_d[k], t1_s[k], NW'(8'h40 + t1_s[k]), 1'b1);
    chk("t1_first_latency", (out_cyc.size() > 0) ? out_cyc[0] : -1, rel + 2);
    if (out_cyc.size() >= 8)
      for (int k = 1; k < 8; k++) chk("t3_gap", out_cyc[k] - out_cyc[k-1], 2);

    // Two 3-beat packets from req 0 and 2, back to back with one idle cycle.
    s = out_d.size();
    push_pkt(0, 3, 32'hA000_0000, 8'h10);
    push_pkt(2, 3, 32'hB000_0000, 8'h22);
    wait_idle("t2");
    chk("t2_count", out_d.size() - s, 6);
    for (int k = 0; k < 3; k++) chk_out("t2a", s + k, 32'hA000_0000 + DW'(k), 0, 8'h10, k == 2);
    for (int k = 0; k < 3; k++) chk_out("t2b", s + 3 + k, 32'hB000_0000 + DW'(k), 2, 8'h22, k == 2);
    if (out_cyc.size() >= s + 6) begin
      chk("t2_in_pkt_gap", out_cyc[s+1] - out_cyc[s], 1);
      chk("t2_between_pkt_gap", out_cyc[s+3] - out_cyc[s+2], 2);
    end

    // fl_ready toggling mid-packet.
    s = out_d.size();
    tog = 1'b1;
    push_pkt(1, 4, 32'hC000_0000, 8'h31);
    wait_idle("t4");
    tog = 1'b0;
    fl_ready = 1'b1;
    chk("t4_count", out_d.size() - s, 4);
    for (int k = 0; k < 4; k++) chk_out("t4", s + k, 32'hC000_0000 + DW'(k), 1, 8'h31, k == 3);

    // 20-beat packet truncated at 16, tail drained, then req 0 served.
    s = out_d.size();
    ovr_cnt = 0;
    push_pkt(3, 20, 32'hD000_0000, 8'h33);
    push_pkt(0, 1, 32'hE000_0000, 8'h44);
    wait_idle("t5");
    chk("t5_count", out_d.size() - s, 17);
    for (int k = 0; k < 16; k++) chk_out("t5", s + k, 32'hD000_0000 + DW'(k), 3, 8'h33, k == 15);
    chk_out("t5_next", s + 16, 32'hE000_0000, 0, 8'h44, 1'b1);
    chk("t5_overrun_pulses", ovr_cnt, 1);

    // Move rr_ptr to 2, then reset during beat 2 of req 2's packet.
    push_pkt(1, 1, 32'hF100_0000, 8'h51);
    wait_idle("t6_pre");
    s = out_d.size();
    push_pkt(2, 4, 32'hF200_0000, 8'h52);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (out_d.size() > s) begin got = 1'b1; break; end
    end
    chk("t6_first_beat", got, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {busy, fl_valid, req_ready, fl_src, fl_dst, overrun_err}, '0);
    for (int i = 0; i < NR; i++) q[i].delete();
    push_pkt(0, 1, 32'hF000_0000, 8'h50);
    push_pkt(2, 1, 32'hF200_0010, 8'h53);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_idle("t6");
    chk("t6_count", out_d.size() - s, 3);
    chk_out("t6_aborted", s, 32'hF200_0000, 2, 8'h52, 1'b0);
    chk_out("t6_after_rst0", s + 1, 32'hF000_0000, 0, 8'h50, 1'b1);
    chk_out("t6_after_rst2", s + 2, 32'hF200_0010, 2, 8'h53, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
